// File: rtl/core_load_store_unit_pkg.sv
// Shared core defines: opcode widths, LSU size codes, FSM states and error causes,
// plus the byte-lane helpers used by the load/store unit.
package core_load_store_unit_pkg;

  localparam int unsigned ALU_OP_WIDTH = 4;
  localparam int unsigned LIS_OP_WIDTH = 3;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_WAIT_R = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_SIZE     = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SIZE_HALF: return off[0];
      SIZE_WORD: return off != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byte_enables(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/core_load_store_unit_extend.sv
// Load lane extraction: picks the byte/half lane named by the address offset
// and sign- or zero-extends it to a full word.
module core_lsu_extend
  import core_load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic        sx;

  always_comb begin
    lane8  = word_i[{offset_i, 3'b000} +: 8];
    lane16 = offset_i[1] ? word_i[31:16] : word_i[15:0];
    sx     = ~unsigned_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{sx & lane8[7]}}, lane8};
      SIZE_HALF: data_o = {{16{sx & lane16[15]}}, lane16};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/core_load_store_unit.sv
// Load/store unit: accepts one core access at a time, issues a single memory
// request with lane-aligned enables/data, and returns a one-cycle response.
module core_load_store_unit
  import core_load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [4:0]              req_rd_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [4:0]              rsp_rd_o,
  output logic                    rsp_err_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-3:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("core_load_store_unit: DATA_WIDTH must be 32");
  end

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  lsu_size_e             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  lsu_err_e              cause_q, cause_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  lsu_size_e             in_size;
  lsu_err_e              in_cause;
  logic                  timeout_hit;
  logic [31:0]           ext_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    cause_d  = cause_q;
    rdata_d  = rdata_q;
    in_size  = lsu_size_e'(req_size_i);
    in_cause = ERR_NONE;
    if (in_size == SIZE_ILL) begin
      in_cause = ERR_SIZE;
    end else if (lsu_misaligned(in_size, req_addr_i[1:0])) begin
      in_cause = ERR_MISALIGN;
    end
    // Saturating count keeps a grant in the final REQ cycle from wrapping the
    // counter; WAIT_R then times out on its first cycle without rvalid.
    timeout_hit = (cnt_q >= CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = in_size;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rd_d    = req_rd_i;
          cause_d = in_cause;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = (in_cause == ERR_NONE) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (mem_gnt_i) begin
          state_d = we_q ? ST_RESP : ST_WAIT_R;
        end else if (timeout_hit) begin
          cause_d = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          cause_d = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cause_q <= ERR_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
    end
  end

  core_lsu_extend u_extend (
    .word_i     (rdata_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    stall_o     = rst_n & ((state_q != ST_IDLE) | req_valid_i);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_rd_o    = '0;
    rsp_err_o   = 1'b0;

    if (state_q == ST_REQ) begin
      mem_req_o  = 1'b1;
      mem_we_o   = we_q;
      mem_addr_o = addr_q[ADDR_WIDTH-1:2];
      mem_be_o   = lsu_byte_enables(size_q, addr_q[1:0]);
      case (size_q)
        SIZE_BYTE: mem_wdata_o = {4{wdata_q[7:0]}};
        SIZE_HALF: mem_wdata_o = {2{wdata_q[15:0]}};
        default:   mem_wdata_o = wdata_q;
      endcase
    end

    if (state_q == ST_RESP) begin
      rsp_valid_o = 1'b1;
      rsp_rd_o    = rd_q;
      rsp_err_o   = (cause_q != ERR_NONE);
      if (!we_q && cause_q == ERR_NONE) begin
        rsp_rdata_o = ext_data;
      end
    end
  end

endmodule

// File: tb/tb_core_load_store_unit.sv
// Directed self-checking bench for core_load_store_unit.
module tb_core_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [9:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o, rsp_err_o, stall_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [7:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  int checks   = 0;
  int failures = 0;
  int req_cnt;

  always #5 clk = ~clk;

  core_load_store_unit #(
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_rd_i       (req_rd_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_rd_o       (rsp_rd_o),
    .rsp_err_o      (rsp_err_o),
    .stall_o        (stall_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one access in IDLE, checks the handshake, and returns just after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_rd_i       = rd;
    req_valid_i    = 1'b1;
    #1;
    chk("issue_ready", req_ready_o, 1);
    chk("issue_stall", stall_o, 1);
    tick();
    req_valid_i = 1'b0;
    req_wdata_i = '0;
  endtask

  // Load with immediate grant; a decoy rvalid in the grant cycle must be ignored.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [7:0] exp_waddr,
                         input logic [4:0] rd, input logic [31:0] word,
                         input logic [31:0] exp, input logic [3:0] exp_be);
    issue(1'b0, size, uns, addr, 32'h0, rd);
    chk({tag, "_req"}, mem_req_o, 1);
    chk({tag, "_we"}, mem_we_o, 0);
    chk({tag, "_be"}, mem_be_o, exp_be);
    chk({tag, "_waddr"}, mem_addr_o, exp_waddr);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = ~word;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    chk({tag, "_wait_rsp"}, rsp_valid_o, 0);
    chk({tag, "_wait_req"}, mem_req_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = word;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
    chk({tag, "_rdata"}, rsp_rdata_o, exp);
    chk({tag, "_rd"}, rsp_rd_o, rd);
    chk({tag, "_err"}, rsp_err_o, 0);
    tick();
    chk({tag, "_idle"}, rsp_valid_o, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_rd_i       = '0;
    mem_gnt_i      = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;

    // Reset values, including stall held low despite a pending request
    #3;
    req_valid_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("idle_stall", stall_o, 0);

    // SW 0x008, immediate grant: response two cycles after acceptance
    issue(1'b1, 2'b10, 1'b0, 10'h008, 32'hDEADBEEF, 5'd5);
    chk("sw_req", mem_req_o, 1);
    chk("sw_we", mem_we_o, 1);
    chk("sw_waddr", mem_addr_o, 8'h02);
    chk("sw_be", mem_be_o, 4'b1111);
    chk("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("sw_ready", req_ready_o, 0);
    chk("sw_stall", stall_o, 1);
    chk("sw_early_rsp", rsp_valid_o, 0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("sw_rsp_valid", rsp_valid_o, 1);
    chk("sw_err", rsp_err_o, 0);
    chk("sw_rd", rsp_rd_o, 5'd5);
    chk("sw_rdata", rsp_rdata_o, 0);
    chk("sw_mem_req_drop", mem_req_o, 0);
    tick();
    chk("sw_idle_valid", rsp_valid_o, 0);
    chk("sw_idle_ready", req_ready_o, 1);

    // SB 0x00D
    issue(1'b1, 2'b00, 1'b0, 10'h00D, 32'h000000A5, 5'd1);
    chk("sb_be", mem_be_o, 4'b0010);
    chk("sb_wdata", mem_wdata_o, 32'hA5A5A5A5);
    chk("sb_waddr", mem_addr_o, 8'h03);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("sb_rsp_valid", rsp_valid_o, 1);
    tick();

    // SH 0x002 with grant withheld: request fields must hold steady
    issue(1'b1, 2'b01, 1'b0, 10'h002, 32'h1234ABCD, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_hold", mem_req_o, 1);
      chk("sh_be_hold", mem_be_o, 4'b1100);
      chk("sh_wdata_hold", mem_wdata_o, 32'hABCDABCD);
      chk("sh_no_rsp", rsp_valid_o, 0);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("sh_rsp_valid", rsp_valid_o, 1);
    chk("sh_rd", rsp_rd_o, 5'd2);
    tick();

    // Loads: lane selection and extension
    do_load("lh",  2'b01, 1'b0, 10'h012, 8'h04, 5'd7,  32'h80017FFF, 32'hFFFF8001, 4'b1100);
    do_load("lhu", 2'b01, 1'b1, 10'h012, 8'h04, 5'd8,  32'h80017FFF, 32'h00008001, 4'b1100);
    do_load("lb",  2'b00, 1'b0, 10'h003, 8'h00, 5'd9,  32'h9A000000, 32'hFFFFFF9A, 4'b1000);
    do_load("lbu", 2'b00, 1'b1, 10'h001, 8'h00, 5'd10, 32'h0000C300, 32'h000000C3, 4'b0010);

    // Misaligned LW 0x006: error response one cycle after acceptance, no memory request
    issue(1'b0, 2'b10, 1'b0, 10'h006, 32'h0, 5'd3);
    chk("mis_mem_req", mem_req_o, 0);
    chk("mis_rsp_valid", rsp_valid_o, 1);
    chk("mis_err", rsp_err_o, 1);
    chk("mis_rdata", rsp_rdata_o, 0);
    chk("mis_rd", rsp_rd_o, 5'd3);
    tick();
    chk("mis_mem_req_after", mem_req_o, 0);
    chk("mis_ready", req_ready_o, 1);

    // Illegal size and misaligned half
    issue(1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 5'd11);
    chk("ill_mem_req", mem_req_o, 0);
    chk("ill_err", rsp_err_o, 1);
    tick();
    issue(1'b1, 2'b01, 1'b0, 10'h001, 32'hFFFF, 5'd12);
    chk("mish_mem_req", mem_req_o, 0);
    chk("mish_err", rsp_err_o, 1);
    tick();

    // Timeout: grant never comes
    issue(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 5'd4);
    req_cnt = 0;
    for (int i = 0; i < 40 && !rsp_valid_o; i++) begin
      if (mem_req_o) req_cnt++;
      tick();
    end
    chk("to_rsp_valid", rsp_valid_o, 1);
    chk("to_err", rsp_err_o, 1);
    chk("to_mem_req_drop", mem_req_o, 0);
    chk("to_req_cycles", req_cnt, 16);
    chk("to_rdata", rsp_rdata_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rdata_i  = 32'hBAD0BAD0;
    tick();
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    chk("late_rsp", rsp_valid_o, 0);
    chk("late_ready", req_ready_o, 1);
    chk("late_mem_req", mem_req_o, 0);
    do_load("lw_after_to", 2'b10, 1'b0, 10'h004, 8'h01, 5'd6, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);

    // Reset asserted while in REQ: mem_req_o falls without waiting for a clock
    issue(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 5'd13);
    chk("rreq_mem_req", mem_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rreq_mem_req_async", mem_req_o, 0);
    chk("rreq_ready", req_ready_o, 1);
    chk("rreq_stall", stall_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted while in WAIT_R: access abandoned, no response pulse
    issue(1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 5'd14);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("rwait_in_wait", rsp_valid_o, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rwait_ready", req_ready_o, 1);
    chk("rwait_mem_req", mem_req_o, 0);
    chk("rwait_rsp", rsp_valid_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rwait_no_rsp", rsp_valid_o, 0);
    end
    mem_rvalid_i = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("rwait_release_rsp", rsp_valid_o, 0);
    chk("rwait_release_ready", req_ready_o, 1);

    // Top-of-space store after reset recovery
    issue(1'b1, 2'b10, 1'b0, 10'h3FC, 32'h11223344, 5'd31);
    chk("top_waddr", mem_addr_o, 8'hFF);
    chk("top_be", mem_be_o, 4'b1111);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("top_rsp_valid", rsp_valid_o, 1);
    chk("top_rd", rsp_rd_o, 5'd31);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
